// File: rtl/fir_da_serial_ctrl.sv
// fir_da_serial_ctrl
// Bit-serial distributed-arithmetic FIR sequencer. Keeps the N_TAPS-deep
// sample delay line, accepts one sample per valid/ready handshake, then walks
// BIT_WIDTH bit-slices through one shared external DA LUT, shift-accumulating
// the LUT outputs into one filtered output sample.
//
// Optional feature macro: FIR_DA_SAT_EN
//   defined   -> output narrowing saturates and a sat_flag output is added
//   undefined -> output narrowing wraps (keeps the low BIT_WIDTH bits)
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous flush of delay line, aborts any conversion
//   in_valid  in   in_data is valid
//   in_ready  out  sample accepted when in_valid && in_ready
//   in_data   in   signed input sample, BIT_WIDTH bits
//   rom_addr  out  LUT address, bit k = bit bit_cnt of tap k (tap 0 newest)
//   rom_data  in   signed LUT output, DA_WIDTH bits, combinational
//   out_valid out  single-cycle result strobe
//   out_data  out  signed filtered sample, held until the next result
//   busy      out  conversion in progress
//   sat_flag  out  (FIR_DA_SAT_EN only) clipping occurred on this result

module fir_da_serial_ctrl #(
    parameter int N_TAPS    = 30,
    parameter int BIT_WIDTH = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [BIT_WIDTH-1:0]                   in_data,
    output logic        [N_TAPS-1:0]                      rom_addr,
    input  logic signed [BIT_WIDTH+$clog2(N_TAPS)-1:0]    rom_data,
    output logic                                          out_valid,
    output logic signed [BIT_WIDTH-1:0]                   out_data,
    output logic                                          busy
`ifdef FIR_DA_SAT_EN
    ,
    output logic                                          sat_flag
`endif
);

    localparam int DA_WIDTH  = BIT_WIDTH + $clog2(N_TAPS);
    localparam int ACC_WIDTH = DA_WIDTH + BIT_WIDTH;
    localparam int CNT_WIDTH = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(BIT_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [BIT_WIDTH-1:0] taps [N_TAPS];
    logic        [CNT_WIDTH-1:0] bit_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] rom_ext;
    logic signed [ACC_WIDTH-1:0] rom_term;
    logic signed [BIT_WIDTH-1:0] result;
    logic                        last_bit;

    assign last_bit = (bit_cnt == LAST_BIT);

    // bit_cnt is forced back to 0 whenever we return to IDLE, so in IDLE this
    // naturally presents the bit-0 slice.
    always_comb begin
        rom_addr = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            rom_addr[k] = taps[k][bit_cnt];
        end
    end

    // The MSB slice carries the negative two's-complement weight, so it is
    // subtracted instead of added.
    always_comb begin
        rom_ext  = {{(ACC_WIDTH-DA_WIDTH){rom_data[DA_WIDTH-1]}}, rom_data};
        rom_term = rom_ext <<< bit_cnt;
        acc_next = last_bit ? (acc - rom_term) : (acc + rom_term);
    end

`ifdef FIR_DA_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_scaled;
    logic                        result_sat;

    always_comb begin
        acc_scaled = acc_next >>> OUT_SHIFT;
        result_sat = 1'b0;
        if (acc_scaled > SAT_MAX) begin
            result     = {1'b0, {(BIT_WIDTH-1){1'b1}}};
            result_sat = 1'b1;
        end else if (acc_scaled < SAT_MIN) begin
            result     = {1'b1, {(BIT_WIDTH-1){1'b0}}};
            result_sat = 1'b1;
        end else begin
            result = BIT_WIDTH'(acc_scaled);
        end
    end
`else
    assign result = BIT_WIDTH'(acc_next >>> OUT_SHIFT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = ACC;
                ACC:     if (last_bit) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:    in_ready = !clear;
            ACC:     busy     = 1'b1;
            default: ;
        endcase
    end

    // Datapath: delay line, bit counter, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) taps[k] <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef FIR_DA_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else if (clear) begin
            for (int k = 0; k < N_TAPS; k++) taps[k] <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    for (int k = N_TAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
                    taps[0] <= in_data;
                    acc     <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                acc <= acc_next;
                if (last_bit) begin
                    bit_cnt   <= '0;
                    out_data  <= result;
                    out_valid <= 1'b1;
`ifdef FIR_DA_SAT_EN
                    sat_flag  <= result_sat;
`endif
                end else begin
                    bit_cnt <= bit_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_da_serial_ctrl.sv
// tb_fir_da_serial_ctrl
// Self-checking bench for fir_da_serial_ctrl with N_TAPS=4, BIT_WIDTH=8,
// OUT_SHIFT=0. The LUT is modelled as the sum of h={1,2,3,4} over the set
// address bits. The reference model computes each result directly as the dot
// product of the coefficient vector with the sample history, then narrows it.

module tb_fir_da_serial_ctrl;

    localparam int N_TAPS    = 4;
    localparam int BIT_WIDTH = 8;
    localparam int OUT_SHIFT = 0;
    localparam int DA_WIDTH  = BIT_WIDTH + $clog2(N_TAPS);
    localparam int LATENCY   = BIT_WIDTH + 1;
    localparam int H [N_TAPS] = '{1, 2, 3, 4};

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        clear;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [BIT_WIDTH-1:0] in_data;
    logic        [N_TAPS-1:0]    rom_addr;
    logic signed [DA_WIDTH-1:0]  rom_data;
    logic                        out_valid;
    logic signed [BIT_WIDTH-1:0] out_data;
    logic                        busy;
`ifdef FIR_DA_SAT_EN
    logic                        sat_flag;
`endif

    fir_da_serial_ctrl #(
        .N_TAPS    (N_TAPS),
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
`ifdef FIR_DA_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int lut_sum;
    always_comb begin
        lut_sum = 0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (rom_addr[k]) lut_sum += H[k];
        end
        rom_data = DA_WIDTH'(lut_sum);
    end

    typedef struct {
        int due;
        int val;
        int sat;
    } exp_t;

    exp_t pend_q[$];
    int   model_taps[N_TAPS];
    int   got_q[$];
    int   acc_cycles[$];
    int   ov_count = 0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic void model_expect(input int full, output int val, output int sat);
        int s;
        s = full >>> OUT_SHIFT;
`ifdef FIR_DA_SAT_EN
        if (s > 127) begin
            val = 127;
            sat = 1;
        end else if (s < -128) begin
            val = -128;
            sat = 1;
        end else begin
            val = s;
            sat = 0;
        end
`else
        begin
            logic [7:0] b;
            b   = s[7:0];
            val = int'($signed(b));
            sat = 0;
        end
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Reference model and per-cycle checker. A handshake seen here lands on
    // the next posedge; its result is due LATENCY negedges after this one.
    bit busy_exp;
    bit ready_exp;
    int full_v;
    int val_v;
    int sat_v;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            for (int k = 0; k < N_TAPS; k++) model_taps[k] = 0;
        end else begin
            busy_exp  = (pend_q.size() > 0) && (pend_q[0].due > cyc);
            ready_exp = !busy_exp && !clear;
            checkOutput("busy", int'(busy), int'(busy_exp));
            checkOutput("in_ready", int'(in_ready), int'(ready_exp));
            if (out_valid === 1'b1) begin
                ov_count++;
                got_q.push_back(int'(out_data));
            end
            if ((pend_q.size() > 0) && (pend_q[0].due == cyc)) begin
                checkOutput("out_valid_pulse", int'(out_valid), 1);
                checkOutput("out_data", int'(out_data), pend_q[0].val);
`ifdef FIR_DA_SAT_EN
                checkOutput("sat_flag", int'(sat_flag), pend_q[0].sat);
`endif
                void'(pend_q.pop_front());
            end else begin
                checkOutput("out_valid_idle", int'(out_valid), 0);
            end
            if (clear) begin
                pend_q.delete();
                for (int k = 0; k < N_TAPS; k++) model_taps[k] = 0;
            end else if (in_valid && ready_exp) begin
                for (int k = N_TAPS - 1; k > 0; k--) model_taps[k] = model_taps[k-1];
                model_taps[0] = int'(in_data);
                full_v = 0;
                for (int k = 0; k < N_TAPS; k++) full_v += H[k] * model_taps[k];
                model_expect(full_v, val_v, sat_v);
                pend_q.push_back('{due: cyc + LATENCY, val: val_v, sat: sat_v});
                acc_cycles.push_back(cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] sample);
        bit accepted;
        accepted = 0;
        in_valid = 1'b1;
        in_data  = sample;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                accepted = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pend_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) checkOutput("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int exp_imp[5] = '{1, 2, 3, 4, 0};
    int exp_neg[5] = '{-1, -2, -3, -4, 0};
    int exp_fresh[4] = '{1, 2, 3, 4};
    int ov0;
    logic [7:0] rnd;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Impulse response
        got_q.delete();
        applyStimulus(8'h01);
        repeat (4) applyStimulus(8'h00);
        drain();
        checkOutput("impulse_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput("impulse_val", got_q[i], exp_imp[i]);

        // Negative impulse exercises the subtracted sign-bit slice
        got_q.delete();
        applyStimulus(8'hFF);
        repeat (4) applyStimulus(8'h00);
        drain();
        checkOutput("neg_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput("neg_val", got_q[i], exp_neg[i]);

        // Overflow: 127 * (1+2+3+4) = 1270
        got_q.delete();
        repeat (4) applyStimulus(8'd127);
        drain();
        checkOutput("ovf_count", got_q.size(), 4);
`ifdef FIR_DA_SAT_EN
        checkOutput("ovf_result", got_q[3], 127);
        checkOutput("ovf_sat_flag", int'(sat_flag), 1);
`else
        checkOutput("ovf_result", got_q[3], -10);
`endif

        // Throughput with in_valid held high
        ov0 = ov_count;
        acc_cycles.delete();
        for (int i = 0; i < 5; i++) begin
            rnd = 8'($urandom());
            applyStimulus(rnd);
        end
        drain();
        checkOutput("tp_pulses", ov_count - ov0, 5);
        checkOutput("tp_accepts", acc_cycles.size(), 5);
        for (int i = 1; i < 5; i++) checkOutput("tp_interval", acc_cycles[i] - acc_cycles[i-1], LATENCY);

        // Clear at bit_cnt=3 aborts the conversion
        applyStimulus(8'h01);
        waitCycles(3);
        ov0   = ov_count;
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        waitCycles(12);
        checkOutput("clear_no_out", ov_count - ov0, 0);
        got_q.delete();
        applyStimulus(8'h01);
        repeat (3) applyStimulus(8'h00);
        drain();
        checkOutput("clear_fresh_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("clear_fresh_val", got_q[i], exp_fresh[i]);

        // Reset at bit_cnt=3 aborts the conversion
        applyStimulus(8'h01);
        waitCycles(3);
        ov0   = ov_count;
        rst_n = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        waitCycles(12);
        checkOutput("rst_no_out", ov_count - ov0, 0);
        got_q.delete();
        applyStimulus(8'h01);
        repeat (3) applyStimulus(8'h00);
        drain();
        checkOutput("rst_fresh_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("rst_fresh_val", got_q[i], exp_fresh[i]);

        // Random samples with random gaps and occasional mid-conversion clears
        for (int n = 0; n < 40; n++) begin
            waitCycles($urandom_range(0, 3));
            rnd = 8'($urandom());
            applyStimulus(rnd);
            if ($urandom_range(0, 7) == 0) begin
                waitCycles($urandom_range(0, 9));
                clear = 1'b1;
                waitCycles(1);
                clear = 1'b0;
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
